// File: rtl/loader_pkg.sv
// Shared definitions for the memory image loader: FSM state encoding and word geometry helpers.
package loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Bytes per memory word.
    function automatic int unsigned bpw(input int unsigned data_width);
        return data_width / 8;
    endfunction

    // Index width that stays at least one bit wide for single-byte words.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/byte_packer.sv
// Collects bytes into DATA_WIDTH words lane by lane; self-clears when a full word is pushed.
module byte_packer
    import loader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BIG_ENDIAN = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clear,
    input  logic                  i_push,
    input  logic [7:0]            i_data,
    output logic [DATA_WIDTH-1:0] o_word_c,
    output logic                  o_full_c
);

    localparam int unsigned     BPW      = bpw(DATA_WIDTH);
    localparam int unsigned     IDXW     = clog2_min1(BPW);
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(BPW - 1);

    logic [DATA_WIDTH-1:0] r_word;
    logic [IDXW-1:0]       r_idx;
    logic [IDXW-1:0]       w_lane;

    assign w_lane   = (BIG_ENDIAN != 0) ? (IDX_LAST - r_idx) : r_idx;
    assign o_full_c = (r_idx == IDX_LAST);

    // Word as it would look with the incoming byte merged into its lane.
    always_comb begin
        o_word_c = r_word;
        for (int i = 0; i < int'(BPW); i++) begin
            if (w_lane == IDXW'(i)) begin
                o_word_c[i*8 +: 8] = i_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_word <= '0;
            r_idx  <= '0;
        end else if (i_push) begin
            if (o_full_c) begin
                r_word <= '0;
                r_idx  <= '0;
            end else begin
                r_word <= o_word_c;
                r_idx  <= r_idx + IDXW'(1);
            end
        end
    end

endmodule

// File: rtl/mem_image_loader.sv
// Streams a byte image into sequential word writes starting at BASE_ADDR, with
// partial-word flush, done/word-count reporting and sticky address overflow.
module mem_image_loader
    import loader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned BASE_ADDR  = 0,
    parameter int unsigned BIG_ENDIAN = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic                  err_overflow
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_BASE = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX  = '1;

    state_e                r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_top_written;
    logic                  r_in_ready;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic                  r_busy;
    logic                  r_done;
    logic [ADDR_WIDTH:0]   r_word_count;
    logic                  r_err;

    logic                  w_start_ok;
    logic                  w_xfer;
    logic                  w_clear;
    logic [DATA_WIDTH-1:0] w_word;
    logic                  w_full;

    assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_xfer     = in_valid && r_in_ready && (r_state == ST_LOAD);
    assign w_clear    = w_start_ok || (w_xfer && in_last);

    byte_packer #(
        .DATA_WIDTH (DATA_WIDTH),
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_packer (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_clear),
        .i_push   (w_xfer),
        .i_data   (in_data),
        .o_word_c (w_word),
        .o_full_c (w_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_addr        <= ADDR_BASE;
            r_top_written <= 1'b0;
            r_in_ready    <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_word_count  <= '0;
            r_err         <= 1'b0;
        end else begin
            r_mem_we <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_start_ok) begin
                        r_state       <= ST_LOAD;
                        r_addr        <= ADDR_BASE;
                        r_top_written <= 1'b0;
                        r_word_count  <= '0;
                        r_err         <= 1'b0;
                        r_in_ready    <= 1'b1;
                        r_busy        <= 1'b1;
                        r_done        <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    r_in_ready <= 1'b1;
                    if (w_xfer && (w_full || in_last)) begin
                        r_in_ready <= 1'b0;
                        if (r_top_written) begin
                            // The top address is already used: drop the word rather than wrap.
                            r_err   <= 1'b1;
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_mem_we     <= 1'b1;
                            r_mem_addr   <= r_addr;
                            r_mem_wdata  <= w_word;
                            r_word_count <= r_word_count + (ADDR_WIDTH + 1)'(1);
                            if (r_addr == ADDR_MAX) begin
                                r_top_written <= 1'b1;
                            end else begin
                                r_addr <= r_addr + ADDR_WIDTH'(1);
                            end
                            if (in_last && w_full) begin
                                r_state <= ST_DONE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end else if (in_last) begin
                                r_state <= ST_FLUSH;
                            end
                        end
                    end
                end
                ST_FLUSH: begin
                    r_state <= ST_DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready     = r_in_ready;
    assign mem_we       = r_mem_we;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign busy         = r_busy;
    assign done         = r_done;
    assign word_count   = r_word_count;
    assign err_overflow = r_err;

endmodule

// File: tb/tb_mem_image_loader.sv
// Scoreboard bench for mem_image_loader: three configurations (LE, BE, tiny address space)
// driven one at a time, with expected writes produced by a word-level reference model.
module tb_mem_image_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_s [3];
    logic        stt   [3];
    logic        vld   [3];
    logic [7:0]  dat   [3];
    logic        lst   [3];
    logic        rdy_s [3];
    logic        we_s  [3];
    logic [31:0] wd_s  [3];
    logic        busy_s[3];
    logic        done_s[3];
    logic        err_s [3];
    logic [31:0] addr_s[3];
    logic [31:0] wc_s  [3];

    logic [15:0] a0, a1;
    logic [1:0]  a2;
    logic [16:0] wc0, wc1;
    logic [2:0]  wc2;

    assign addr_s[0] = 32'(a0);
    assign addr_s[1] = 32'(a1);
    assign addr_s[2] = 32'(a2);
    assign wc_s[0]   = 32'(wc0);
    assign wc_s[1]   = 32'(wc1);
    assign wc_s[2]   = 32'(wc2);

    mem_image_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .BASE_ADDR(0), .BIG_ENDIAN(0)) u_le (
        .clk(clk), .rst(rst_s[0]), .start(stt[0]), .in_valid(vld[0]), .in_data(dat[0]),
        .in_last(lst[0]), .in_ready(rdy_s[0]), .mem_we(we_s[0]), .mem_addr(a0),
        .mem_wdata(wd_s[0]), .busy(busy_s[0]), .done(done_s[0]), .word_count(wc0),
        .err_overflow(err_s[0]));

    mem_image_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .BASE_ADDR(0), .BIG_ENDIAN(1)) u_be (
        .clk(clk), .rst(rst_s[1]), .start(stt[1]), .in_valid(vld[1]), .in_data(dat[1]),
        .in_last(lst[1]), .in_ready(rdy_s[1]), .mem_we(we_s[1]), .mem_addr(a1),
        .mem_wdata(wd_s[1]), .busy(busy_s[1]), .done(done_s[1]), .word_count(wc1),
        .err_overflow(err_s[1]));

    mem_image_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(2), .BASE_ADDR(3), .BIG_ENDIAN(0)) u_ov (
        .clk(clk), .rst(rst_s[2]), .start(stt[2]), .in_valid(vld[2]), .in_data(dat[2]),
        .in_last(lst[2]), .in_ready(rdy_s[2]), .mem_we(we_s[2]), .mem_addr(a2),
        .mem_wdata(wd_s[2]), .busy(busy_s[2]), .done(done_s[2]), .word_count(wc2),
        .err_overflow(err_s[2]));

    typedef struct {
        int          d;
        int          a;
        logic [31:0] w;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: split the image into 4-byte words, zero-pad the tail, place bytes by
    // endianness, and stop at the first word whose address lies beyond the address space.
    function automatic void model(input int d, input logic [7:0] img[$],
                                  output int acc, output int nw, output bit ovf);
        int   n     = img.size();
        int   base  = (d == 2) ? 3 : 0;
        int   amax  = (d == 2) ? 3 : 65535;
        bit   be    = (d == 1);
        int   nword = (n + 3) / 4;
        exp_t e;
        acc = n;
        nw  = 0;
        ovf = 1'b0;
        for (int k = 0; k < nword; k++) begin
            if (base + k > amax) begin
                ovf = 1'b1;
                acc = (n < 4 * k + 4) ? n : 4 * k + 4;
                break;
            end
            e.d = d;
            e.a = base + k;
            e.w = '0;
            for (int j = 0; j < 4; j++) begin
                logic [31:0] b;
                b   = (4 * k + j < n) ? 32'(img[4 * k + j]) : 32'd0;
                e.w = e.w | (b << (8 * (be ? 3 - j : j)));
            end
            sb.push_back(e);
            nw++;
        end
    endfunction

    // Monitor: every write strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (we_s[d] === 1'b1) begin
                check("ready_low_during_write", 64'(rdy_s[d]), 64'd0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: dut%0d addr %0h data %0h, none expected",
                             d, addr_s[d], wd_s[d]);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("write_dut", 64'(d), 64'(e.d));
                    check("write_addr", 64'(addr_s[d]), 64'(e.a));
                    check("write_data", 64'(wd_s[d]), 64'(e.w));
                end
            end
        end
    end

    // Offer bytes until acc of them have been accepted; in_last marks the image's final byte.
    task automatic drive(input int d, input logic [7:0] img[$], input int acc,
                         input bit gaps, input int start_at);
        int i     = 0;
        int guard = 0;
        bit xfer;
        bit pulsed = 1'b0;
        while (i < acc && guard < 4000) begin
            guard++;
            if (gaps && $urandom_range(3) == 0) begin
                vld[d] = 1'b0;
                dat[d] = 8'($urandom);
                lst[d] = 1'b0;
            end else begin
                vld[d] = 1'b1;
                dat[d] = img[i];
                lst[d] = (i == img.size() - 1);
            end
            if (i == start_at && !pulsed) begin
                stt[d] = 1'b1;
                pulsed = 1'b1;
            end
            @(negedge clk);
            xfer = vld[d] && rdy_s[d];
            @(posedge clk);
            #1;
            stt[d] = 1'b0;
            if (xfer) i++;
        end
        vld[d] = 1'b0;
        lst[d] = 1'b0;
        check("drive_accepted", 64'(i), 64'(acc));
    endtask

    task automatic pulse_start(input int d, input bit junk);
        vld[d] = junk;
        dat[d] = 8'hA5;
        lst[d] = junk;
        stt[d] = 1'b1;
        @(posedge clk);
        #1;
        stt[d] = 1'b0;
    endtask

    task automatic run_image(input int d, input logic [7:0] img[$], input bit gaps,
                             input int start_at, input bit junk);
        int acc, nw, t;
        bit ovf;
        model(d, img, acc, nw, ovf);
        if (junk) begin
            vld[d] = 1'b1;
            dat[d] = 8'h5A;
            lst[d] = 1'b1;
            repeat (2) @(posedge clk);
            #1;
        end
        pulse_start(d, junk);
        drive(d, img, acc, gaps, start_at);
        t = 0;
        while (done_s[d] !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        repeat (2) @(negedge clk);
        check("done", 64'(done_s[d]), 64'd1);
        check("busy_after_done", 64'(busy_s[d]), 64'd0);
        check("ready_after_done", 64'(rdy_s[d]), 64'd0);
        check("word_count", 64'(wc_s[d]), 64'(nw));
        check("err_overflow", 64'(err_s[d]), 64'(ovf));
        check("writes_outstanding", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input int d);
        check("rst_mem_we", 64'(we_s[d]), 64'd0);
        check("rst_mem_addr", 64'(addr_s[d]), 64'd0);
        check("rst_mem_wdata", 64'(wd_s[d]), 64'd0);
        check("rst_busy", 64'(busy_s[d]), 64'd0);
        check("rst_done", 64'(done_s[d]), 64'd0);
        check("rst_word_count", 64'(wc_s[d]), 64'd0);
        check("rst_err", 64'(err_s[d]), 64'd0);
        check("rst_in_ready", 64'(rdy_s[d]), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] img[$];
        for (int d = 0; d < 3; d++) begin
            rst_s[d] = 1'b1;
            stt[d]   = 1'b0;
            vld[d]   = 1'b0;
            dat[d]   = 8'h00;
            lst[d]   = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) rst_s[d] = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) check_zero(d);
        @(posedge clk);
        #1;

        img = {8'h11, 8'h22, 8'h33, 8'h44};
        run_image(0, img, 1'b0, -1, 1'b0);
        run_image(1, img, 1'b0, -1, 1'b0);

        img = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        run_image(0, img, 1'b0, -1, 1'b0);

        img = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        run_image(2, img, 1'b0, -1, 1'b0);

        // Reset with three bytes of a word pending: nothing may be written.
        img = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
        pulse_start(0, 1'b0);
        drive(0, img, 3, 1'b0, -1);
        rst_s[0] = 1'b1;
        @(posedge clk);
        #1;
        rst_s[0] = 1'b0;
        @(negedge clk);
        check_zero(0);
        @(posedge clk);
        #1;
        run_image(0, img, 1'b0, -1, 1'b0);

        for (int it = 0; it < 24; it++) begin
            int len;
            len = int'($urandom_range(23, 1));
            img.delete();
            for (int k = 0; k < len; k++) img.push_back(8'($urandom));
            run_image(it % 3, img, 1'b1, int'($urandom_range(len - 1)), 1'b1);
        end

        repeat (5) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
